check_input: RTL and testbench

CHECK_INPUT -- requirements
Module: check_input

---
 rtl/check_input_if.sv | 26 ++
 rtl/check_input.sv | 91 +++++++++
 tb/tb_check_input.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/check_input_if.sv
// check_input_if: pattern/button inputs and check status outputs of check_input.
interface check_input_if;
    logic       enable;
    logic [2:0] level;
    logic [2:0] pattern_1, pattern_2, pattern_3, pattern_4;
    logic [2:0] pattern_5, pattern_6, pattern_7, pattern_8;
    logic [2:0] pattern_9, pattern_10, pattern_11, pattern_12;
    logic [2:0] pattern_13, pattern_14, pattern_15, pattern_16;
    logic [7:0] btn;
    logic       busy;
    logic       check_end;
    logic       check_pass;
    logic [4:0] press_count;
    modport master (
        output enable, level, btn,
        output pattern_1, pattern_2, pattern_3, pattern_4, pattern_5, pattern_6, pattern_7, pattern_8,
        output pattern_9, pattern_10, pattern_11, pattern_12, pattern_13, pattern_14, pattern_15, pattern_16,
        input  busy, check_end, check_pass, press_count
    );
    modport slave (
        input  enable, level, btn,
        input  pattern_1, pattern_2, pattern_3, pattern_4, pattern_5, pattern_6, pattern_7, pattern_8,
        input  pattern_9, pattern_10, pattern_11, pattern_12, pattern_13, pattern_14, pattern_15, pattern_16,
        output busy, check_end, check_pass, press_count
    );
endinterface

// File: rtl/check_input.sv
// check_input: checks the player's button presses against a snapshotted pattern sequence.
// Optional per-press timeout when INPUT_TIMEOUT_EN is defined.
module check_input #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input logic         clk_1,
    input logic         rst,
    check_input_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT_PRESS, WAIT_RELEASE, DONE} state_t;
    state_t           state_q, state_d;
    logic [15:0][2:0] pat_q, pat_d, pat_in;
    logic [4:0]       n_q, n_d, cnt_q, cnt_d;
    logic             pass_q, pass_d, end_q;
    logic [7:0]       btn_q;
    logic             press, hit, timeout;
    assign pat_in = {bus.pattern_16, bus.pattern_15, bus.pattern_14, bus.pattern_13,
                     bus.pattern_12, bus.pattern_11, bus.pattern_10, bus.pattern_9,
                     bus.pattern_8, bus.pattern_7, bus.pattern_6, bus.pattern_5,
                     bus.pattern_4, bus.pattern_3, bus.pattern_2, bus.pattern_1};
    // A press is a rising edge of "any button", so buttons held from before never count
    assign press = bus.btn != 8'd0 && btn_q == 8'd0;
    assign hit   = bus.btn == (8'd1 << pat_q[cnt_q[3:0]]);
`ifdef INPUT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer_q, timer_d;
    assign timeout = timer_q == TW'(TIMEOUT_CYCLES - 1);
    always_comb
        timer_d = (state_d == WAIT_PRESS && state_q != WAIT_PRESS) ? '0 :
                  (state_q == WAIT_PRESS) ? timer_q + 1'b1 : timer_q;
    always_ff @(posedge clk_1)
        timer_q <= rst ? '0 : timer_d;
`else
    assign timeout = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        unique case (state_q)
            IDLE, DONE: if (bus.enable) begin
                pat_d   = pat_in;
                n_d     = bus.level >= 3'd6 ? 5'd16 : 5'd4 + {1'b0, bus.level, 1'b0};
                cnt_d   = 5'd0;
                state_d = WAIT_PRESS;
            end
            WAIT_PRESS: if (press) begin
                if (hit) begin
                    cnt_d   = cnt_q + 5'd1;
                    state_d = WAIT_RELEASE;
                end else begin
                    pass_d  = 1'b0;
                    state_d = DONE;
                end
            end else if (timeout) begin
                pass_d  = 1'b0;
                state_d = DONE;
            end
            WAIT_RELEASE: if (bus.btn == 8'd0) begin
                pass_d  = cnt_q == n_q;
                state_d = cnt_q == n_q ? DONE : WAIT_PRESS;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_1) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
            end_q   <= 1'b0;
            btn_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            end_q   <= state_d == DONE && state_q != DONE;
            btn_q   <= bus.btn;
        end
    end
    assign bus.busy        = state_q == WAIT_PRESS || state_q == WAIT_RELEASE;
    assign bus.check_end   = end_q;
    assign bus.check_pass  = pass_q;
    assign bus.press_count = cnt_q;
endmodule

// File: tb/tb_check_input.sv
// tb_check_input: table-driven vectors plus directed corner sequences for check_input.
module tb_check_input;
    logic clk_1 = 1'b0;
    logic rst   = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   ends = 0;
    check_input_if bus ();
    check_input #(.TIMEOUT_CYCLES(20)) dut (.clk_1(clk_1), .rst(rst), .bus(bus));
    always #5 clk_1 = ~clk_1;
    always @(negedge clk_1) if (bus.check_end === 1'b1) ends++;

    typedef struct {
        logic [2:0]       level;
        logic [15:0][2:0] pats;
        logic [15:0][7:0] presses;
        int               np;
        logic             pass;
        logic [4:0]       cnt;
    } vec_t;
    vec_t vecs[6];

    task automatic tick();
        @(posedge clk_1);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_pats(input logic [15:0][2:0] p);
        bus.pattern_1  = p[0];  bus.pattern_2  = p[1];  bus.pattern_3  = p[2];  bus.pattern_4  = p[3];
        bus.pattern_5  = p[4];  bus.pattern_6  = p[5];  bus.pattern_7  = p[6];  bus.pattern_8  = p[7];
        bus.pattern_9  = p[8];  bus.pattern_10 = p[9];  bus.pattern_11 = p[10]; bus.pattern_12 = p[11];
        bus.pattern_13 = p[12]; bus.pattern_14 = p[13]; bus.pattern_15 = p[14]; bus.pattern_16 = p[15];
    endtask

    task automatic start(input logic [2:0] lvl, input logic [15:0][2:0] p);
        set_pats(p);
        bus.level  = lvl;
        bus.enable = 1'b1;
        tick();
        bus.enable = 1'b0;
        set_pats(~p);
        bus.level = ~lvl;
    endtask

    task automatic press(input logic [7:0] b);
        bus.btn = b;
        tick();
        bus.btn = 8'h00;
        tick();
    endtask

    task automatic run_vec(input vec_t v);
        int e0;
        e0 = ends;
        start(v.level, v.pats);
        chk("vec_start_busy", 32'(bus.busy), 32'd1);
        chk("vec_start_count", 32'(bus.press_count), 32'd0);
        for (int i = 0; i < v.np; i++) press(v.presses[i]);
        tick();
        chk("vec_end_pulses", 32'(ends - e0), 32'd1);
        chk("vec_pass", 32'(bus.check_pass), 32'(v.pass));
        chk("vec_count", 32'(bus.press_count), 32'(v.cnt));
        chk("vec_idle_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [15:0][2:0] p4, p16;
        int e0;
        p4 = '0;
        p4[0] = 3'd2; p4[1] = 3'd5; p4[2] = 3'd0; p4[3] = 3'd7;
        for (int i = 0; i < 16; i++) p16[i] = 3'(i % 8);
        foreach (vecs[k]) begin
            vecs[k].pats = '0;
            vecs[k].presses = '0;
        end
        vecs[0].level = 3'd0; vecs[0].pats = p4; vecs[0].np = 4; vecs[0].pass = 1'b1; vecs[0].cnt = 5'd4;
        vecs[0].presses[0] = 8'h04; vecs[0].presses[1] = 8'h20; vecs[0].presses[2] = 8'h01; vecs[0].presses[3] = 8'h80;
        vecs[1].level = 3'd0; vecs[1].pats = p4; vecs[1].np = 2; vecs[1].pass = 1'b0; vecs[1].cnt = 5'd1;
        vecs[1].presses[0] = 8'h04; vecs[1].presses[1] = 8'h08;
        vecs[2].level = 3'd7; vecs[2].pats = p16; vecs[2].np = 16; vecs[2].pass = 1'b1; vecs[2].cnt = 5'd16;
        for (int i = 0; i < 16; i++) vecs[2].presses[i] = 8'(1 << (i % 8));
        vecs[3].level = 3'd0; vecs[3].pats = p4; vecs[3].np = 1; vecs[3].pass = 1'b0; vecs[3].cnt = 5'd0;
        vecs[3].presses[0] = 8'h06;
        vecs[4].level = 3'd1; vecs[4].np = 6; vecs[4].pass = 1'b1; vecs[4].cnt = 5'd6;
        vecs[4].pats[0] = 3'd3; vecs[4].pats[1] = 3'd3; vecs[4].pats[2] = 3'd1;
        vecs[4].pats[3] = 3'd6; vecs[4].pats[4] = 3'd4; vecs[4].pats[5] = 3'd0;
        vecs[4].presses[0] = 8'h08; vecs[4].presses[1] = 8'h08; vecs[4].presses[2] = 8'h02;
        vecs[4].presses[3] = 8'h40; vecs[4].presses[4] = 8'h10; vecs[4].presses[5] = 8'h01;
        vecs[5].level = 3'd2; vecs[5].np = 8; vecs[5].pass = 1'b0; vecs[5].cnt = 5'd7;
        for (int i = 0; i < 8; i++) vecs[5].pats[i] = 3'(7 - i);
        for (int i = 0; i < 7; i++) vecs[5].presses[i] = 8'(1 << (7 - i));
        vecs[5].presses[7] = 8'h02;

        bus.enable = 1'b0;
        bus.level  = 3'd0;
        bus.btn    = 8'h00;
        set_pats('0);
        tick();
        tick();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_end", 32'(bus.check_end), 32'd0);
        chk("rst_pass", 32'(bus.check_pass), 32'd0);
        chk("rst_count", 32'(bus.press_count), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_busy", 32'(bus.busy), 32'd0);

        foreach (vecs[k]) run_vec(vecs[k]);

        start(3'd0, p4);
        press(8'h04);
        bus.btn = 8'h08;
        tick();
        chk("lat_fail_end", 32'(bus.check_end), 32'd1);
        chk("lat_fail_busy", 32'(bus.busy), 32'd0);
        bus.btn = 8'h00;
        tick();
        chk("end_one_cycle", 32'(bus.check_end), 32'd0);

        start(3'd0, p4);
        press(8'h04);
        bus.enable = 1'b1;
        tick();
        bus.enable = 1'b0;
        chk("enable_ignored_count", 32'(bus.press_count), 32'd1);
        chk("enable_ignored_busy", 32'(bus.busy), 32'd1);
        press(8'h20);
        press(8'h01);
        bus.btn = 8'h80;
        tick();
        tick();
        chk("held_last_busy", 32'(bus.busy), 32'd1);
        chk("held_last_end", 32'(bus.check_end), 32'd0);
        chk("held_last_count", 32'(bus.press_count), 32'd4);
        bus.btn = 8'h00;
        tick();
        chk("lat_pass_end", 32'(bus.check_end), 32'd1);
        chk("lat_pass_pass", 32'(bus.check_pass), 32'd1);

        start(3'd7, p16);
        for (int i = 0; i < 15; i++) press(8'(1 << (i % 8)));
        chk("fifteen_busy", 32'(bus.busy), 32'd1);
        chk("fifteen_count", 32'(bus.press_count), 32'd15);
        bus.btn = 8'h80;
        tick();
        bus.btn = 8'h00;
        tick();
        chk("sixteen_end", 32'(bus.check_end), 32'd1);
        chk("sixteen_pass", 32'(bus.check_pass), 32'd1);

        bus.btn = 8'h04;
        start(3'd0, p4);
        tick();
        tick();
        chk("held_start_count", 32'(bus.press_count), 32'd0);
        chk("held_start_busy", 32'(bus.busy), 32'd1);
        bus.btn = 8'h00;
        tick();
        press(8'h04);
        chk("repress_count", 32'(bus.press_count), 32'd1);
        press(8'h20);
        chk("two_presses", 32'(bus.press_count), 32'd2);
        e0 = ends;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_count", 32'(bus.press_count), 32'd0);
        chk("abort_pass", 32'(bus.check_pass), 32'd0);
        chk("abort_end", 32'(bus.check_end), 32'd0);
        tick();
        tick();
        chk("abort_no_pulse", 32'(ends - e0), 32'd0);

        start(3'd0, p4);
        for (int i = 0; i < 19; i++) tick();
        chk("wait_19_busy", 32'(bus.busy), 32'd1);
        tick();
`ifdef INPUT_TIMEOUT_EN
        chk("timeout_end", 32'(bus.check_end), 32'd1);
        chk("timeout_pass", 32'(bus.check_pass), 32'd0);
`else
        chk("no_timeout_busy", 32'(bus.busy), 32'd1);
        chk("no_timeout_end", 32'(bus.check_end), 32'd0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
